// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Bundles the raw input and the conditioned outputs of input_conditioner.
//   d_i        : raw single-bit input (driven by the producer)
//   level_o    : debounced level
//   rise_o     : one-cycle pulse on a level_o 0->1 transition
//   fall_o     : one-cycle pulse on a level_o 1->0 transition
//   stable_o   : 1 when no transition is pending
//   edge_cnt_o : count of rise_o pulses, wraps modulo 256
// master : the side that drives d_i and consumes the conditioned outputs
// slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface input_conditioner_if;
  logic       d_i;
  logic       level_o;
  logic       rise_o;
  logic       fall_o;
  logic       stable_o;
  logic [7:0] edge_cnt_o;

  modport master (
    output d_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  stable_o,
    input  edge_cnt_o
  );

  modport slave (
    input  d_i,
    output level_o,
    output rise_o,
    output fall_o,
    output stable_o,
    output edge_cnt_o
  );
endinterface

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronizes a raw single-bit input, debounces it with a four-state FSM and
// emits registered one-cycle rise/fall pulses plus a wrapping rise counter.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous, active-low reset
//   bus   : input_conditioner_if.slave (d_i in; level/rise/fall/stable/count out)
// Parameters:
//   SYNC_STAGES     : synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES : consecutive differing samples needed to accept a change (>= 1)
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input_conditioner_if.slave    bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first differing sample completes the change.
  localparam logic SHORTCUT = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    PEND_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    PEND_LOW  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  state_e                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   level_r, level_nxt_s;
  logic                   rise_r, rise_nxt_s;
  logic                   fall_r, fall_nxt_s;
  logic [7:0]             edge_cnt_r;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronizer shift chain; zeroed by reset so latency restarts from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.d_i};
    end
  end

  // Debounce FSM next-state and next-output decode.
  // cnt holds the number of consecutive differing samples seen so far, so
  // entering a PEND state already counts the first one.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        cnt_nxt_s = '0;
        if (s_s && SHORTCUT) begin
          state_nxt_s = IDLE_HIGH;
          level_nxt_s = 1'b1;
          rise_nxt_s  = 1'b1;
        end else if (s_s) begin
          state_nxt_s = PEND_HIGH;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_LOW;
        end
      end
      PEND_HIGH: begin
        if (!s_s) begin
          state_nxt_s = IDLE_LOW;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_HIGH;
          cnt_nxt_s   = '0;
          level_nxt_s = 1'b1;
          rise_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        cnt_nxt_s = '0;
        if (!s_s && SHORTCUT) begin
          state_nxt_s = IDLE_LOW;
          level_nxt_s = 1'b0;
          fall_nxt_s  = 1'b1;
        end else if (!s_s) begin
          state_nxt_s = PEND_LOW;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE_HIGH;
        end
      end
      PEND_LOW: begin
        if (s_s) begin
          state_nxt_s = IDLE_HIGH;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_LOW;
          cnt_nxt_s   = '0;
          level_nxt_s = 1'b0;
          fall_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LOW;
        cnt_nxt_s   = '0;
        level_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, level and pulse registers; reset wins over a completing change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE_LOW;
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  // Rising-edge counter, stepped on the same edge that raises rise_o.
  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_cnt_r <= 8'd0;
    end else if (rise_nxt_s) begin
      edge_cnt_r <= edge_cnt_r + 8'd1;
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  assign bus.level_o    = level_r;
  assign bus.rise_o     = rise_r;
  assign bus.fall_o     = fall_r;
  assign bus.stable_o   = (state_r == IDLE_LOW) || (state_r == IDLE_HIGH);
  assign bus.edge_cnt_o = edge_cnt_r;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4). A directed vector table covers reset
// hold, rise, fall, glitch rejection and reset mid-pending; loops cover the
// counter wrap and a random-run-length comparison against a run-length model.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  logic clk = 1'b0;
  logic reset;

  input_conditioner_if ic_if ();

  input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ic_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       d;
    logic       level;
    logic       rise;
    logic       fall;
    logic       stable;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state for the random section
  logic       h0, h1, s_m, cur, m_level, m_rise, m_fall;
  int         m_run, run_left;
  logic [7:0] m_cnt;

  task automatic add(input logic r, input logic d, input logic l, input logic ri,
                     input logic f, input logic st, input logic [7:0] c);
    vec_t v;
    v.rst_n = r; v.d = d; v.level = l; v.rise = ri; v.fall = f; v.stable = st; v.cnt = c;
    vecs.push_back(v);
  endtask

  // Apply inputs, let one rising edge pass, then settle away from the edge.
  task automatic step(input logic r, input logic d);
    reset     = r;
    ic_if.d_i = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {ic_if.level_o, ic_if.rise_o, ic_if.fall_o, ic_if.stable_o, ic_if.edge_cnt_o};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lvl,rise,fall,stable,cnt}=%b_%h expected %b_%h",
               name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  initial begin
    // reset hold with d=1, then release: rise 5 edges after release edge
    repeat (3) add(0, 1, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 1, 8'd0);
    repeat (3) add(1, 1, 0, 0, 0, 0, 8'd0);
    add(1, 1, 1, 1, 0, 1, 8'd1);
    add(1, 1, 1, 0, 0, 1, 8'd1);
    // fall: d=0 from edge k, fall_o after k+5, counter unchanged
    add(1, 0, 1, 0, 0, 1, 8'd1);
    add(1, 0, 1, 0, 0, 1, 8'd1);
    repeat (3) add(1, 0, 1, 0, 0, 0, 8'd1);
    add(1, 0, 0, 0, 1, 1, 8'd1);
    add(1, 0, 0, 0, 0, 1, 8'd1);
    // glitch: d=1 for 3 edges then 0, stable low for 3 cycles, no rise
    add(1, 1, 0, 0, 0, 1, 8'd1);
    add(1, 1, 0, 0, 0, 1, 8'd1);
    add(1, 1, 0, 0, 0, 0, 8'd1);
    add(1, 0, 0, 0, 0, 0, 8'd1);
    add(1, 0, 0, 0, 0, 0, 8'd1);
    repeat (3) add(1, 0, 0, 0, 0, 1, 8'd1);
    // reset mid-pending: d=1 from k, reset at k+3, rise 5 edges after release
    add(1, 1, 0, 0, 0, 1, 8'd1);
    add(1, 1, 0, 0, 0, 1, 8'd1);
    add(1, 1, 0, 0, 0, 0, 8'd1);
    add(0, 1, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 0, 1, 8'd0);
    repeat (3) add(1, 1, 0, 0, 0, 0, 8'd0);
    add(1, 1, 1, 1, 0, 1, 8'd1);
    add(1, 1, 1, 0, 0, 1, 8'd1);

    reset     = 1'b0;
    ic_if.d_i = 1'b1;
    #2;

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].d);
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].level, vecs[i].rise, vecs[i].fall, vecs[i].stable, vecs[i].cnt});
    end

    // counter wrap: 256 accepted rises from a fresh reset
    step(0, 0);
    check("wrap_reset", obs(), {4'b0001, 8'd0});
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 8; j++) step(1, 0);
      for (int j = 0; j < 8; j++) step(1, 1);
      check($sformatf("wrap%0d", i), obs(), {4'b1001, 8'((i + 1) % 256)});
    end

    // random run lengths 1..8 against a run-length reference model
    step(0, 0);
    h0 = 1'b0; h1 = 1'b0; cur = 1'b0; m_level = 1'b0; m_run = 0; m_cnt = 8'd0; run_left = 0;
    for (int c = 0; c < 2000; c++) begin
      if (run_left == 0) begin
        cur      = ~cur;
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      step(1, cur);
      s_m    = h1;
      h1     = h0;
      h0     = cur;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s_m != m_level) begin
        m_run++;
        if (m_run == 4) begin
          m_level = s_m;
          m_run   = 0;
          if (s_m) begin
            m_rise = 1'b1;
            m_cnt  = m_cnt + 8'd1;
          end else begin
            m_fall = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      check($sformatf("rand%0d", c), obs() & 12'hEFF,
            {m_level, m_rise, m_fall, 1'b0, m_cnt});
      check($sformatf("mutex%0d", c), {11'd0, ic_if.rise_o & ic_if.fall_o}, 12'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
